result_writer: RTL and testbench
================================

Name: result_writer

Overview:
- Writer side of the result-RAM (dram) port A; the counterpart to the VGA controller, which reads the result RAM through port B.
- Accepts a stream of 8-bit result pixels from the processing core through a valid/ready handshake.
- Packs every 4 pixels into one 32-bit word, buffers words in a small FIFO, and writes them to sequential dram addresses starting at a per-quadrant base.
- Signals completion once a full quadrant has been written.

Parameters:
- ADDR_W, 18, width of ram_address.
- PIXEL_COUNT, 10000, pixels per quadrant job (>=1).
- QUAD_WORDS, 2500, word stride between quadrant bases (>= ceil(PIXEL_COUNT/4)).
- FIFO_DEPTH, 4, word FIFO entries (power of 2, >=2).

Ports:
- clock  in  1  system clock; all logic on rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  job request; sampled only in IDLE.
- quadrant  in  32  quadrant select; bits [1:0] latched at an accepted start, other bits ignored.
- in_valid  in  1  pixel valid from the core.
- in_pixel  in  8  pixel value.
- in_ready  out  1  writer accepts in_pixel this cycle.
- ram_grant  in  1  writer owns dram port A this cycle.
- ram_address  out  ADDR_W  dram port A address (registered).
- ram_data  out  32  dram port A write data (registered).
- ram_wen  out  1  dram port A write enable (registered).
- busy  out  1  job in progress.
- done  out  1  one-cycle pulse at job end.

Behaviour:
- Reset (reset=0): all outputs 0, FSM=IDLE, FIFO empty, lane/pixel/word counters 0. Reset asserted mid-job aborts immediately; no further writes are issued.
- FSM states and transitions:
  - IDLE: start=1 latches base = quadrant[1:0]*QUAD_WORDS (ADDR_W bits), sets busy=1, then goes to RUN.
  - RUN: accepts pixels. After the edge that accepts pixel PIXEL_COUNT-1, goes to FLUSH.
  - FLUSH: in_ready=0. Goes to DONE when the FIFO is empty and the final write has been driven.
  - DONE: done=1 for one cycle, busy=0 from this cycle, then returns to IDLE.
- start is ignored outside IDLE.
- in_ready = (state==RUN) && !fifo_full, where fifo_full is the registered flag.
- A transfer occurs on a rising edge when in_valid && in_ready.
- Packing: the byte lane counter is 0..3. Pixel k of each word goes to bits [8k+7:8k] (little-endian).
- A word is pushed into the FIFO on the same edge that accepts lane 3, or the last pixel of the job. Unfilled lanes of a final partial word are 0.
- Pop rule: when the FIFO is non-empty and ram_grant=1, pop one word. On the next edge, drive ram_wen=1, ram_data=word, ram_address=base+word_index, then increment word_index.
  - Otherwise ram_wen=0 on the next edge; ram_address and ram_data hold their previous values.
- Latency: a word pushed at edge k with ram_grant high has ram_wen=1 after edge k+1, so dram samples it at edge k+2.
- Sustained throughput: one write per cycle while ram_grant=1.
- Simultaneous push and pop: allowed when not full; occupancy is unchanged.
- Push into an empty FIFO: the word is poppable on the next cycle. There is no bypass.
- A push into a full FIFO is impossible, because of the in_ready guard.
- ram_grant dropping mid-stream stalls pops only. Packing continues until the FIFO fills.
- Address arithmetic is modulo 2^ADDR_W. Callers size QUAD_WORDS so that no wrap occurs.

Optional Feature:
- Macro: RESULT_WRITER_CHECKSUM_EN.
- Defined: adds output checksum [31:0]. It is cleared at accepted start, adds each written ram_data (modulo 2^32) on every ram_wen=1 cycle, and holds its value after done until the next start.
- Undefined: no checksum port or logic; all other behaviour is identical.

Test Plan:
- Basic job: PIXEL_COUNT=8, QUAD_WORDS=2, quadrant=0, ram_grant=1, pixels 0x01..0x08 streamed back to back. Expect writes addr0=0x04030201 and addr1=0x08070605, done pulse, busy low after done.
- Quadrant base: same setup with quadrant=32'h00000003. Expect writes to addr 6 and 7; quadrant=32'hFFFFFFF1 writes to addr 2 and 3.
- Partial word: PIXEL_COUNT=6, pixels 0x01..0x06. Expect second word 0x00000605 and exactly 2 writes.
- Backpressure: FIFO_DEPTH=4, ram_grant=0, PIXEL_COUNT=40. Expect in_ready low after 16 pixels accepted and no ram_wen. Then raise ram_grant: 4 writes on 4 consecutive cycles, after which in_ready returns high.
- start ignored while busy: pulse start with quadrant=1 mid-job. Expect base unchanged and a single done pulse.
- Reset mid-job: drive reset=0 after 5 pixels. Expect all outputs 0 and FSM in IDLE. A new job then starts with word_index 0.
- With RESULT_WRITER_CHECKSUM_EN defined, the basic job ends with checksum=0x0C0A0806.

Source files
------------

// File: rtl/result_writer.sv
// result_writer: packs 8-bit result pixels into 32-bit words and writes them to dram port A.
// Define RESULT_WRITER_CHECKSUM_EN to add a running 32-bit sum of written words.
module result_writer #(
    parameter int ADDR_W      = 18,
    parameter int PIXEL_COUNT = 10000,
    parameter int QUAD_WORDS  = 2500,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [31:0]       quadrant,
    input  logic              in_valid,
    input  logic [7:0]        in_pixel,
    output logic              in_ready,
    input  logic              ram_grant,
    output logic [ADDR_W-1:0] ram_address,
    output logic [31:0]       ram_data,
    output logic              ram_wen,
`ifdef RESULT_WRITER_CHECKSUM_EN
    output logic [31:0]       checksum,
`endif
    output logic              busy,
    output logic              done
);
    localparam int PW = $clog2(PIXEL_COUNT + 1);
    localparam int FW = $clog2(FIFO_DEPTH);
    typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;
    state_t state, state_nx;
    logic [ADDR_W-1:0] base, word_idx;
    logic [PW-1:0] pix_cnt;
    logic [1:0] lane;
    logic [23:0] pack;
    logic [31:0] mem [FIFO_DEPTH];
    logic [FW-1:0] wr_ptr, rd_ptr;
    logic [FW:0] count;
    logic fifo_full, fifo_empty, accept, xfer, last, push, pop;
    logic [31:0] word;
    logic unused_quadrant;
    assign unused_quadrant = ^quadrant[31:2];
    assign fifo_full  = count == (FW+1)'(FIFO_DEPTH);
    assign fifo_empty = count == '0;
    assign accept = state == IDLE && start;
    assign xfer   = in_valid && in_ready;
    assign last   = pix_cnt == PW'(PIXEL_COUNT - 1);
    assign push   = xfer && (lane == 2'd3 || last);
    assign pop    = !fifo_empty && ram_grant;
    // Lanes above the current one are still zero in pack, so a partial final word is zero-padded.
    assign word   = {8'h00, pack} | ({24'h0, in_pixel} << {lane, 3'b000});
    always_comb begin
        state_nx = state == IDLE  ? (start ? RUN : IDLE)
                 : state == RUN   ? (xfer && last ? FLUSH : RUN)
                 : state == FLUSH ? (fifo_empty ? DONE : FLUSH)
                 : IDLE;
        in_ready = state == RUN && !fifo_full;
        busy     = state == RUN || state == FLUSH;
        done     = state == DONE;
    end
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            base        <= '0;
            word_idx    <= '0;
            pix_cnt     <= '0;
            lane        <= '0;
            pack        <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            ram_address <= '0;
            ram_data    <= '0;
            ram_wen     <= 1'b0;
        end else begin
            state   <= state_nx;
            ram_wen <= pop;
            count   <= count + (FW+1)'(push) - (FW+1)'(pop);
            if (accept) begin
                base     <= ADDR_W'(quadrant[1:0]) * ADDR_W'(QUAD_WORDS);
                word_idx <= '0;
                pix_cnt  <= '0;
                lane     <= '0;
                pack     <= '0;
            end
            if (xfer) begin
                pix_cnt <= pix_cnt + PW'(1);
                lane    <= push ? 2'd0 : lane + 2'd1;
                pack    <= push ? 24'h0 : word[23:0];
            end
            if (push)
                wr_ptr <= wr_ptr + FW'(1);
            if (pop) begin
                rd_ptr      <= rd_ptr + FW'(1);
                ram_data    <= mem[rd_ptr];
                ram_address <= base + word_idx;
                word_idx    <= word_idx + ADDR_W'(1);
            end
        end
    end
    always_ff @(posedge clock)
        if (push)
            mem[wr_ptr] <= word;
`ifdef RESULT_WRITER_CHECKSUM_EN
    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            checksum <= '0;
        else if (accept)
            checksum <= '0;
        else if (ram_wen)
            checksum <= checksum + ram_data;
    end
`endif
endmodule

// File: tb/tb_result_writer.sv
// tb_result_writer: randomized jobs checked against a word-level model of the packed result stream.
module tb_result_writer;
    localparam int AW = 18;
    localparam int PC = 22;
    localparam int QW = 6;
    localparam int FD = 4;
    localparam int NW = (PC + 3) / 4;

    logic clock, reset, start, in_valid, in_ready, ram_grant, ram_wen, busy, done;
    logic [31:0] quadrant, ram_data;
    logic [7:0] in_pixel;
    logic [AW-1:0] ram_address;
`ifdef RESULT_WRITER_CHECKSUM_EN
    logic [31:0] checksum;
`endif

    result_writer #(.ADDR_W(AW), .PIXEL_COUNT(PC), .QUAD_WORDS(QW), .FIFO_DEPTH(FD)) dut (
        .clock(clock), .reset(reset), .start(start), .quadrant(quadrant),
        .in_valid(in_valid), .in_pixel(in_pixel), .in_ready(in_ready),
        .ram_grant(ram_grant), .ram_address(ram_address), .ram_data(ram_data),
        .ram_wen(ram_wen),
`ifdef RESULT_WRITER_CHECKSUM_EN
        .checksum(checksum),
`endif
        .busy(busy), .done(done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_tests = 0;
    int n_fail = 0;
    int cyc = 0;
    int done_cnt = 0;
    int idx = 0;
    logic [31:0] cur_q;
    logic [7:0] px [PC];
    logic [AW-1:0] wr_addr [$];
    logic [31:0] wr_data [$];
    int wr_cyc [$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clock);
        #1;
    endtask

    always @(negedge clock) begin
        cyc++;
        if (ram_wen) begin
            wr_addr.push_back(ram_address);
            wr_data.push_back(ram_data);
            wr_cyc.push_back(cyc);
        end
        if (done) begin
            done_cnt++;
            check("busy_at_done", busy, 0);
        end
    end

    task automatic clear_log();
        wr_addr.delete();
        wr_data.delete();
        wr_cyc.delete();
        done_cnt = 0;
    endtask

    task automatic begin_job(input logic [31:0] q, input bit seq);
        for (int i = 0; i < PC; i++)
            px[i] = seq ? 8'(i + 1) : 8'($urandom);
        cur_q = q;
        idx = 0;
        tick();
        clear_log();
        start = 1'b1;
        quadrant = q;
        tick();
        start = 1'b0;
        quadrant = $urandom;
        check("busy_after_start", busy, 1);
    endtask

    task automatic stream(input int n, input int vpct, input int gpct, input bit poke);
        int guard = 0;
        while (idx < n && guard < 3000) begin
            tick();
            ram_grant = $urandom_range(99) < gpct;
            start = poke && (guard % 5 == 2);
            if (poke)
                quadrant = 32'd1;
            in_valid = $urandom_range(99) < vpct;
            in_pixel = px[idx];
            if (in_valid && in_ready)
                idx++;
            guard++;
        end
        tick();
        in_valid = 1'b0;
        start = 1'b0;
        check("stream_len", idx, n);
    endtask

    task automatic finish_job();
        int guard = 0;
        bit seen = 0;
        logic [31:0] sum = 0;
        in_valid = 1'b0;
        while (!seen && guard < 200) begin
            tick();
            ram_grant = 1'b1;
            seen = done;
            guard++;
        end
        repeat (3) tick();
        check("done_seen", seen, 1);
        check("done_pulses", done_cnt, 1);
        check("busy_idle", busy, 0);
        check("write_count", wr_data.size(), NW);
        for (int w = 0; w < NW && w < wr_data.size(); w++) begin
            logic [31:0] d;
            d = 0;
            for (int k = 0; k < 4; k++)
                if (4 * w + k < PC)
                    d[8*k +: 8] = px[4*w + k];
            check("wr_addr", wr_addr[w], (int'(cur_q[1:0]) * QW + w) % (1 << AW));
            check("wr_data", wr_data[w], d);
            sum += d;
        end
`ifdef RESULT_WRITER_CHECKSUM_EN
        check("checksum", checksum, sum);
`endif
    endtask

    initial begin
        int gap;
        reset = 1'b0;
        start = 1'b0;
        quadrant = '0;
        in_valid = 1'b0;
        in_pixel = '0;
        ram_grant = 1'b0;
        repeat (3) tick();
        check("rst_in_ready", in_ready, 0);
        check("rst_wen", ram_wen, 0);
        check("rst_addr", ram_address, 0);
        check("rst_data", ram_data, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        reset = 1'b1;

        begin_job(32'h0, 1);
        stream(PC, 100, 100, 0);
        finish_job();
        check("basic_word0", (wr_data.size() > 0) ? wr_data[0] : 32'h0, 32'h04030201);

        begin_job(32'h3, 0);
        stream(PC, 70, 60, 1);
        finish_job();

        begin_job(32'hFFFFFFF1, 0);
        stream(PC, 50, 50, 0);
        finish_job();

        begin_job(32'h0, 0);
        repeat (30) begin
            tick();
            ram_grant = 1'b0;
            in_valid = 1'b1;
            in_pixel = px[idx];
            if (in_ready)
                idx++;
        end
        tick();
        in_valid = 1'b0;
        check("bp_accepted", idx, 4 * FD);
        check("bp_in_ready", in_ready, 0);
        check("bp_no_writes", wr_data.size(), 0);
        ram_grant = 1'b1;
        repeat (6) tick();
        gap = wr_cyc.size() >= 4 ? wr_cyc[3] - wr_cyc[0] : -1;
        check("bp_drain_count", wr_data.size(), FD);
        check("bp_drain_gap", gap, FD - 1);
        check("bp_ready_back", in_ready, 1);
        stream(PC, 80, 70, 0);
        finish_job();

        begin_job(32'h2, 0);
        stream(5, 100, 50, 0);
        reset = 1'b0;
        #1;
        check("mid_rst_in_ready", in_ready, 0);
        check("mid_rst_wen", ram_wen, 0);
        check("mid_rst_addr", ram_address, 0);
        check("mid_rst_data", ram_data, 0);
        check("mid_rst_busy", busy, 0);
        clear_log();
        repeat (3) tick();
        check("mid_rst_no_writes", wr_data.size(), 0);
        check("mid_rst_no_done", done_cnt, 0);
        reset = 1'b1;
        tick();

        begin_job(32'h0, 0);
        stream(PC, 90, 80, 0);
        finish_job();

        repeat (4) begin
            begin_job($urandom, 0);
            stream(PC, $urandom_range(30, 100), $urandom_range(20, 100), 0);
            finish_job();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
